// File: rtl/usb_endpi_buffer.sv
// usb_endpi_buffer: IN-endpoint packet buffer between a CPU I/O bus and a USB SIE.
//   The CPU fills the buffer through the DATA register and arms it through CTRL.
//   The SIE then drains the armed packet byte by byte. It can rewind the packet
//   for a retransmit, or acknowledge it to finish the transfer.
// Parameters:
//   BASE_ADDR - CTRL register address; DATA register is at BASE_ADDR+2
//   DEPTH     - packet buffer size in bytes (power of two, 8..64)
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   io_addr/io_din       - CPU address / write data
//   io_we/io_re          - single-cycle CPU write / read strobes
//   io_dout              - registered read data (0 when no matching read)
//   sie_armed/sie_empty  - packet ready / no byte available for the SIE
//   sie_data             - byte at the read pointer (combinational)
//   sie_rd/sie_ack/sie_retry - SIE pop, host ACK, rewind-for-retransmit
//   sie_stall            - endpoint stalled
// Build option:
//   USB_ENDPI_STALL_EN - makes CTRL bit13 a writable stall bit that drives
//                        sie_stall and masks sie_armed; otherwise stall is 0.
module usb_endpi_buffer #(
  parameter logic [15:0] BASE_ADDR = 16'h5000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_din,
  input  logic        io_we,
  input  logic        io_re,
  output logic [15:0] io_dout,
  output logic        sie_armed,
  output logic [7:0]  sie_data,
  output logic        sie_empty,
  input  logic        sie_rd,
  input  logic        sie_ack,
  input  logic        sie_retry,
  output logic        sie_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] DATA_ADDR = 16'(BASE_ADDR + 16'd2);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   count_q, count_nxt;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_nxt;
  logic            done_q, done_nxt;
  logic            ovf_q, ovf_nxt;
  logic            stall_q, stall_nxt;
  logic [15:0]     io_dout_nxt;
  logic            sie_armed_nxt;
  logic            sie_empty_nxt;
  logic            mem_we_c;
  logic            ctrl_wr_c;
  logic            data_wr_c;
  logic [15:0]     ctrl_rd_c;
  logic [7:0]      mem_q [DEPTH];
  logic            unused_ok;

  // Only the flag bits and the low data byte of io_din carry meaning.
  assign unused_ok = ^io_din[13:8];

  assign ctrl_wr_c = io_we && (io_addr == BASE_ADDR);
  assign data_wr_c = io_we && (io_addr == DATA_ADDR);
  assign ctrl_rd_c = {done_q, (state_q == ST_ARMED), stall_q, ovf_q, 5'd0, 7'(count_q)};

  // rd_ptr can equal DEPTH once a full packet is drained; the index wraps harmlessly.
  assign sie_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign sie_stall = stall_q;

  // Packet RAM: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[count_q[AW-1:0]] <= io_din[7:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FILL;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      stall_q   <= 1'b0;
      io_dout   <= '0;
      sie_armed <= 1'b0;
      sie_empty <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      rd_ptr_q  <= rd_ptr_nxt;
      done_q    <= done_nxt;
      ovf_q     <= ovf_nxt;
      stall_q   <= stall_nxt;
      io_dout   <= io_dout_nxt;
      sie_armed <= sie_armed_nxt;
      sie_empty <= sie_empty_nxt;
    end
  end

  // Next-state, register updates and next values of the registered outputs.
  always_comb begin
    state_nxt   = state_q;
    count_nxt   = count_q;
    rd_ptr_nxt  = rd_ptr_q;
    done_nxt    = done_q;
    ovf_nxt     = ovf_q;
    stall_nxt   = stall_q;
    mem_we_c    = 1'b0;
    io_dout_nxt = '0;

    if (io_re && (io_addr == BASE_ADDR)) begin
      io_dout_nxt = ctrl_rd_c;
    end

`ifdef USB_ENDPI_STALL_EN
    if (ctrl_wr_c) begin
      stall_nxt = io_din[13];
    end
`endif

    if (ctrl_wr_c && io_din[15]) begin
      // Flush overrides arming and any coincident SIE event.
      state_nxt  = ST_FILL;
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      done_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (data_wr_c) begin
            if (count_q == CW'(DEPTH)) begin
              ovf_nxt = 1'b1;
            end else begin
              mem_we_c  = 1'b1;
              count_nxt = count_q + CW'(1);
            end
          end else if (ctrl_wr_c && io_din[14]) begin
            state_nxt  = ST_ARMED;
            rd_ptr_nxt = '0;
          end
        end
        ST_ARMED: begin
          if (sie_ack) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else if (sie_retry) begin
            rd_ptr_nxt = '0;
          end else if (sie_rd && !sie_empty && !stall_q) begin
            rd_ptr_nxt = rd_ptr_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_FILL;
        end
      endcase
    end

    sie_armed_nxt = (state_nxt == ST_ARMED) && !stall_nxt;
    sie_empty_nxt = (state_nxt != ST_ARMED) || (rd_ptr_nxt == count_nxt);
  end

endmodule

// File: tb/tb_usb_endpi_buffer.sv
// Directed self-checking bench for usb_endpi_buffer (default parameters).
module tb_usb_endpi_buffer;

  localparam logic [15:0] CTRL = 16'h5000;
  localparam logic [15:0] DATA = 16'h5002;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_addr;
  logic [15:0] io_din;
  logic        io_we;
  logic        io_re;
  logic [15:0] io_dout;
  logic        sie_armed;
  logic [7:0]  sie_data;
  logic        sie_empty;
  logic        sie_rd;
  logic        sie_ack;
  logic        sie_retry;
  logic        sie_stall;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] rd;

  usb_endpi_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_din    (io_din),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_dout   (io_dout),
    .sie_armed (sie_armed),
    .sie_data  (sie_data),
    .sie_empty (sie_empty),
    .sie_rd    (sie_rd),
    .sie_ack   (sie_ack),
    .sie_retry (sie_retry),
    .sie_stall (sie_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_addr = addr; io_din = data; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0; io_addr = '0; io_din = '0;
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    io_addr = addr; io_re = 1'b1;
    @(negedge clk);
    data = io_dout;
    io_re = 1'b0; io_addr = '0;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: sie_rd = 1'b1;
      1: sie_retry = 1'b1;
      default: sie_ack = 1'b1;
    endcase
    @(negedge clk);
    sie_rd = 1'b0; sie_retry = 1'b0; sie_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [3];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    reset = 1'b1; io_addr = '0; io_din = '0; io_we = 1'b0; io_re = 1'b0;
    sie_rd = 1'b0; sie_ack = 1'b0; sie_retry = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_armed", 16'(sie_armed), 16'h0);
    check("rst_empty", 16'(sie_empty), 16'h1);
    check("rst_stall", 16'(sie_stall), 16'h0);
    check("rst_dout", io_dout, 16'h0);
    reset = 1'b0;

    // Three-byte packet, drained in order.
    for (int i = 0; i < 3; i++) io_write(DATA, {8'hA5, pkt[i]});
    io_write(CTRL, 16'h4000);
    io_read(CTRL, rd);
    check("arm3_ctrl", rd, 16'h4003);
    check("arm3_armed", 16'(sie_armed), 16'h1);
    check("arm3_empty", 16'(sie_empty), 16'h0);
    for (int i = 0; i < 3; i++) begin
      check("pop_data", 16'(sie_data), 16'(pkt[i]));
      pulse(0);
    end
    check("drained_empty", 16'(sie_empty), 16'h1);
    pulse(0);
    io_read(CTRL, rd);
    check("pop_empty_ignored", rd, 16'h4003);
    pulse(2);
    io_read(CTRL, rd);
    check("ack3_ctrl", rd, 16'h8003);
    io_write(CTRL, 16'h8000);
    io_read(CTRL, rd);
    check("flush_ctrl", rd, 16'h0000);

    // Retry rewinds to the first byte.
    io_write(DATA, 16'h00AA);
    io_write(DATA, 16'h00BB);
    io_write(CTRL, 16'h4000);
    pulse(0);
    check("second_byte", 16'(sie_data), 16'h00BB);
    pulse(0);
    check("two_empty", 16'(sie_empty), 16'h1);
    pulse(1);
    check("retry_data", 16'(sie_data), 16'h00AA);
    check("retry_empty", 16'(sie_empty), 16'h0);
    check("retry_armed", 16'(sie_armed), 16'h1);
    pulse(2);
    io_read(CTRL, rd);
    check("ack2_ctrl", rd, 16'h8002);
    check("ack2_armed", 16'(sie_armed), 16'h0);
    check("ack2_empty", 16'(sie_empty), 16'h1);
    pulse(0);
    pulse(1);
    io_read(CTRL, rd);
    check("done_ignores_sie", rd, 16'h8002);
    io_write(CTRL, 16'h8000);

    // Overflow: DEPTH+1 writes.
    for (int i = 0; i < 65; i++) io_write(DATA, 16'(i));
    io_read(CTRL, rd);
    check("ovf_ctrl", rd, 16'h1040);
    io_write(CTRL, 16'h8000);
    io_read(CTRL, rd);
    check("ovf_flush", rd, 16'h0000);

    // DATA writes while armed are dropped silently.
    io_write(DATA, 16'h0077);
    io_write(CTRL, 16'h4000);
    io_write(DATA, 16'h0088);
    io_read(CTRL, rd);
    check("armed_data_drop", rd, 16'h4001);
    check("armed_data_byte", 16'(sie_data), 16'h0077);
    io_write(CTRL, 16'h8000);

    // Zero-length packet.
    io_write(CTRL, 16'h4000);
    check("zlp_armed", 16'(sie_armed), 16'h1);
    check("zlp_empty", 16'(sie_empty), 16'h1);
    pulse(2);
    io_read(CTRL, rd);
    check("zlp_ack", rd, 16'h8000);
    io_write(CTRL, 16'h8000);

    // Flush wins over a coincident ack.
    io_write(DATA, 16'h0055);
    io_write(CTRL, 16'h4000);
    @(negedge clk);
    io_addr = CTRL; io_din = 16'h8000; io_we = 1'b1; sie_ack = 1'b1;
    @(negedge clk);
    io_we = 1'b0; sie_ack = 1'b0; io_addr = '0; io_din = '0;
    io_read(CTRL, rd);
    check("flush_ack_ctrl", rd, 16'h0000);
    check("flush_ack_armed", 16'(sie_armed), 16'h0);

    // Write-only DATA and unmatched address read as zero.
    io_write(DATA, 16'h0001);
    io_read(DATA, rd);
    check("data_read", rd, 16'h0000);
    io_read(16'h1234, rd);
    check("bad_addr_read", rd, 16'h0000);
    io_write(CTRL, 16'h8000);

    // Reset in the middle of a transfer.
    for (int i = 0; i < 4; i++) io_write(DATA, 16'(8'hC0 + i));
    io_write(CTRL, 16'h4000);
    pulse(0);
    check("mid_data", 16'(sie_data), 16'h00C1);
    @(negedge clk);
    io_addr = CTRL; io_re = 1'b1;
    @(posedge clk);
    #1;
    check("mid_dout", io_dout, 16'h4004);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", io_dout, 16'h0);
    check("mid_rst_armed", 16'(sie_armed), 16'h0);
    check("mid_rst_empty", 16'(sie_empty), 16'h1);
    check("mid_rst_stall", 16'(sie_stall), 16'h0);
    io_re = 1'b0; io_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    io_read(CTRL, rd);
    check("post_rst_ctrl", rd, 16'h0000);

    // Stall bit.
    io_write(CTRL, 16'h2000);
`ifdef USB_ENDPI_STALL_EN
    check("stall_on", 16'(sie_stall), 16'h1);
    io_read(CTRL, rd);
    check("stall_ctrl", rd, 16'h2000);
`else
    check("stall_tied", 16'(sie_stall), 16'h0);
    io_read(CTRL, rd);
    check("stall_ctrl", rd, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_endpi_buffer.md
USB_ENDPI_BUFFER -- requirements
Module: usb_endpi_buffer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h5000, giving the CTRL register address; DATA sits at BASE_ADDR+2.
REQ-002 The block SHALL have parameter DEPTH, default 64, giving the packet buffer size in bytes (power of two, 8..64).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port io_addr, input, 16 bits: CPU I/O address.
REQ-006 Port io_din, input, 16 bits: CPU write data.
REQ-007 Port io_we, input, 1 bit: CPU write strobe, one cycle per access.
REQ-008 Port io_re, input, 1 bit: CPU read strobe, one cycle per access.
REQ-009 Port io_dout, output, 16 bits: registered read data.
REQ-010 Port sie_armed, output, 1 bit: a packet is ready for the SIE.
REQ-011 Port sie_data, output, 8 bits: byte at the read pointer (combinational from the buffer).
REQ-012 Port sie_empty, output, 1 bit: no byte is available to the SIE.
REQ-013 Port sie_rd, input, 1 bit: SIE pops one byte.
REQ-014 Port sie_ack, input, 1 bit: one-cycle pulse; host ACKed the packet.
REQ-015 Port sie_retry, input, 1 bit: one-cycle pulse; no ACK, so rewind for retransmit.
REQ-016 Port sie_stall, output, 1 bit: endpoint stalled (see Configuration).

Function
REQ-017 The CTRL read format SHALL be [15] done, [14] armed, [13] stall, [12] overflow, [6:0] byte count; other bits 0.
REQ-018 A CPU read SHALL present data on io_dout one cycle after io_re; an unmatched address or no read SHALL give 16'h0000.
REQ-019 A DATA read SHALL return 16'h0000; DATA is write-only.
REQ-020 States: FILL, ARMED, DONE; reset state SHALL be FILL.
REQ-021 FILL: a DATA write SHALL store io_din[7:0] at wr_ptr and increment the count; a write when count==DEPTH SHALL be dropped and SHALL set overflow (sticky).
REQ-022 FILL: a CTRL write with bit14=1 SHALL go to ARMED with rd_ptr=0; a zero count is legal (zero-length packet, sie_empty=1 at once).
REQ-023 ARMED: sie_armed=1; sie_empty SHALL be 1 when rd_ptr==count; sie_rd with sie_empty=0 SHALL increment rd_ptr; sie_rd with sie_empty=1 SHALL be ignored.
REQ-024 ARMED: sie_retry SHALL reset rd_ptr to 0 and stay in ARMED; buffer contents and count are unchanged.
REQ-025 ARMED: sie_ack SHALL go to DONE and set done=1; if sie_ack and sie_retry coincide, sie_ack wins.
REQ-026 ARMED or DONE: DATA writes SHALL be dropped without setting overflow.
REQ-027 Any state: a CTRL write with bit15=1 (flush) SHALL clear count, rd_ptr, done and overflow and go to FILL; flush has priority over bit14 and over a coincident sie_ack or sie_rd.
REQ-028 Outside ARMED: sie_armed=0 and sie_empty=1; sie_rd, sie_ack and sie_retry SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL immediately force FILL, count=0, rd_ptr=0, done=0, overflow=0, stall=0, io_dout=0, sie_armed=0, sie_empty=1 and sie_stall=0, including in the middle of a transfer; buffer RAM contents are not reset.

Configuration
REQ-030 With macro USB_ENDPI_STALL_EN defined, CTRL bit13 SHALL be writable on every CTRL write, SHALL drive sie_stall, and a set stall SHALL hold sie_armed=0 while otherwise keeping the current state.
REQ-031 Without USB_ENDPI_STALL_EN, CTRL bit13 SHALL read 0, writes to it SHALL be ignored, and sie_stall SHALL be tied to 0.

Verification
REQ-032 Write 3 DATA bytes 8'h11, 8'h22, 8'h33, then CTRL 16'h4000 -> CTRL reads 16'h4003; sie_data then shows 11, 22, 33 over three sie_rd pops, after which sie_empty=1.
REQ-033 Arm 2 bytes, pop both, pulse sie_retry -> rd_ptr=0 and sie_data=first byte again; then sie_ack -> CTRL reads 16'h8002 and sie_armed=0.
REQ-034 Write DEPTH+1 DATA bytes -> count=DEPTH, CTRL bit12=1; a CTRL write of 16'h8000 -> CTRL reads 16'h0000.
REQ-035 Arm an empty buffer -> sie_armed=1 and sie_empty=1; sie_ack -> done=1 with count 0.
REQ-036 Flush and sie_ack in the same cycle while in ARMED -> FILL state and CTRL reads 16'h0000.
REQ-037 Assert reset mid-transfer after 1 of 4 bytes is popped -> all outputs at reset values on the same cycle; with USB_ENDPI_STALL_EN, a CTRL write of 16'h2000 -> sie_stall=1.
